conv_kernel_engine: RTL and testbench

- Parametrised successor to the fixed 3x3 box-filter stage in the image-processing pipeline.
- Takes one KSIZE x KSIZE pixel window per beat from the line-buffer/window stage and applies a runtime-loadable signed kernel.
- Normalises by rounded right shift, saturates to pixel range, emits one pixel per beat.
- Full AXI-stream backpressure; coefficient bank is double-buffered so kernel changes never corrupt in-flight pixels.

---
 rtl/conv_kernel_engine_pkg.sv | 24 ++
 rtl/conv_kernel_engine_if.sv | 12 +
 rtl/conv_kernel_engine_coef_bank.sv | 46 ++++
 rtl/conv_kernel_engine.sv | 148 ++++++++++++++
 tb/tb_conv_kernel_engine.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_kernel_engine_pkg.sv
// Shared constants, types and helpers for the parametrised convolution engine.
package conv_kernel_engine_pkg;

    localparam int PIX_W_DEF         = 8;
    localparam int KSIZE_DEF         = 3;
    localparam int COEF_W_DEF        = 8;
    localparam int SHIFT_W_DEF       = 4;
    localparam int IDENT_CENTRE_COEF = 1;

    typedef struct packed {
        logic valid;
        logic last;
    } stage_ctrl_t;

    // Wide enough that no NTAPS-term sum of pixel*coef products can overflow.
    function automatic int acc_w(input int pix_w, input int coef_w, input int ntaps);
        return pix_w + 1 + coef_w + $clog2(ntaps);
    endfunction

    function automatic int ident_coef(input int tap, input int ntaps);
        return (tap == ntaps / 2) ? IDENT_CENTRE_COEF : 0;
    endfunction

endpackage

// File: rtl/conv_kernel_engine_if.sv
// Valid/ready stream bundle with last marker; one instance per direction.
interface conv_kernel_engine_if #(
    parameter int W = 8
);
    logic         valid;
    logic [W-1:0] data;
    logic         last;
    logic         ready;

    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/conv_kernel_engine_coef_bank.sv
// Double-buffered coefficient bank: writes land in shadow, commit copies shadow
// and the presented shift into the active bank in a single cycle.
module conv_kernel_engine_coef_bank
    import conv_kernel_engine_pkg::*;
#(
    parameter  int NTAPS   = 9,
    parameter  int COEF_W  = 8,
    parameter  int SHIFT_W = 4,
    localparam int ADDR_W  = $clog2(NTAPS)
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_coef_we,
    input  logic [ADDR_W-1:0]             i_coef_addr,
    input  logic [COEF_W-1:0]             i_coef_data,
    input  logic [SHIFT_W-1:0]            i_shift,
    input  logic                          i_commit,
    output logic [NTAPS-1:0][COEF_W-1:0]  o_coef,
    output logic [SHIFT_W-1:0]            o_shift
);

    logic [NTAPS-1:0][COEF_W-1:0] shadow_q;
    logic                         addr_ok;

    assign addr_ok = ({1'b0, i_coef_addr} < (ADDR_W + 1)'(NTAPS));

    // Commit reads the pre-write shadow, so a same-cycle write is not committed.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                shadow_q[k] <= COEF_W'(ident_coef(k, NTAPS));
                o_coef[k]   <= COEF_W'(ident_coef(k, NTAPS));
            end
            o_shift <= '0;
        end else begin
            if (i_commit) begin
                o_coef  <= shadow_q;
                o_shift <= i_shift;
            end
            if (i_coef_we && addr_ok) begin
                shadow_q[i_coef_addr] <= i_coef_data;
            end
        end
    end

endmodule

// File: rtl/conv_kernel_engine.sv
// KSIZE x KSIZE signed-kernel convolution: multiply, sum, round/shift/saturate,
// three registered stages with full valid/ready backpressure.
module conv_kernel_engine
    import conv_kernel_engine_pkg::*;
#(
    parameter  int PIX_W   = PIX_W_DEF,
    parameter  int KSIZE   = KSIZE_DEF,
    parameter  int COEF_W  = COEF_W_DEF,
    parameter  int SHIFT_W = SHIFT_W_DEF,
    localparam int NTAPS   = KSIZE * KSIZE,
    localparam int ADDR_W  = $clog2(NTAPS)
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    conv_kernel_engine_if.slave  s_in,
    conv_kernel_engine_if.master m_out,
    input  logic                i_coef_we,
    input  logic [ADDR_W-1:0]   i_coef_addr,
    input  logic [COEF_W-1:0]   i_coef_data,
    input  logic [SHIFT_W-1:0]  i_shift,
    input  logic                i_commit,
    output logic                o_sat,
    input  logic                i_sat_clr
);

    localparam int PROD_W = PIX_W + 1 + COEF_W;
    localparam int ACC_W  = acc_w(PIX_W, COEF_W, NTAPS);
    localparam logic signed [ACC_W:0] Y_MAX = (ACC_W + 1)'((1 << PIX_W) - 1);

    logic [NTAPS-1:0][COEF_W-1:0] act_coef;
    logic [SHIFT_W-1:0]           act_shift;

    stage_ctrl_t               s1_q, s2_q, s3_q;
    logic signed [PROD_W-1:0]  prod_d [NTAPS];
    logic signed [PROD_W-1:0]  prod_q [NTAPS];
    logic signed [ACC_W-1:0]   sum_d, sum_q;
    logic [SHIFT_W-1:0]        shift1_q, shift2_q;
    logic signed [ACC_W:0]     rnd, y;
    logic [PIX_W-1:0]          pix_d, pix_q;
    logic                      clamp;
    logic                      adv1, adv2, adv3, in_fire, s3_load;

    conv_kernel_engine_coef_bank #(
        .NTAPS   (NTAPS),
        .COEF_W  (COEF_W),
        .SHIFT_W (SHIFT_W)
    ) u_bank (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_coef_we   (i_coef_we),
        .i_coef_addr (i_coef_addr),
        .i_coef_data (i_coef_data),
        .i_shift     (i_shift),
        .i_commit    (i_commit),
        .o_coef      (act_coef),
        .o_shift     (act_shift)
    );

    // A stage may load when it is empty or its contents move on this cycle.
    assign adv3    = !s3_q.valid || m_out.ready;
    assign adv2    = !s2_q.valid || adv3;
    assign adv1    = !s1_q.valid || adv2;
    assign in_fire = s_in.valid && adv1;
    assign s3_load = adv3 && s2_q.valid;

    assign s_in.ready  = adv1;
    assign m_out.valid = s3_q.valid;
    assign m_out.data  = pix_q;
    assign m_out.last  = s3_q.last;

    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            prod_d[k] = PROD_W'($signed({1'b0, s_in.data[PIX_W*k +: PIX_W]}))
                      * PROD_W'($signed(act_coef[k]));
        end
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NTAPS; k++) begin
            sum_d = sum_d + ACC_W'(prod_q[k]);
        end
    end

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        rnd = (ACC_W + 1)'(sum_q);
        if (shift2_q != '0) begin
            rnd = rnd + ((ACC_W + 1)'(1) <<< (shift2_q - 1'b1));
        end
        y     = rnd >>> shift2_q;
        clamp = 1'b0;
        pix_d = y[PIX_W-1:0];
        if (y[ACC_W]) begin
            pix_d = '0;
            clamp = 1'b1;
        end else if (y > Y_MAX) begin
            pix_d = '1;
            clamp = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            shift1_q <= '0;
            shift2_q <= '0;
            sum_q    <= '0;
            pix_q    <= '0;
            o_sat    <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                prod_q[k] <= '0;
            end
        end else begin
            if (adv1) begin
                s1_q.valid <= in_fire;
            end
            if (in_fire) begin
                s1_q.last <= s_in.last;
                prod_q    <= prod_d;
                shift1_q  <= act_shift;
            end
            if (adv2) begin
                s2_q.valid <= s1_q.valid;
            end
            if (adv2 && s1_q.valid) begin
                s2_q.last <= s1_q.last;
                sum_q     <= sum_d;
                shift2_q  <= shift1_q;
            end
            if (adv3) begin
                s3_q.valid <= s2_q.valid;
            end
            if (s3_load) begin
                s3_q.last <= s2_q.last;
                pix_q     <= pix_d;
            end
            if (s3_load && clamp) begin
                o_sat <= 1'b1;
            end else if (i_sat_clr) begin
                o_sat <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_kernel_engine.sv
// Self-checking bench for conv_kernel_engine: vector table, commit/reset
// sequences and a randomized backpressured stream against an arithmetic model.
module tb_conv_kernel_engine;

    localparam int PIX_W = 8;
    localparam int NTAPS = 9;
    localparam int WIN_W = NTAPS * PIX_W;
    localparam int KER_W = NTAPS * 8;
    localparam int NSTREAM = 40;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic       i_reset_n;
    logic       coef_we;
    logic [3:0] coef_addr;
    logic [7:0] coef_data;
    logic [3:0] shift;
    logic       commit;
    logic       o_sat;
    logic       sat_clr;

    conv_kernel_engine_if #(.W(WIN_W)) in_if ();
    conv_kernel_engine_if #(.W(PIX_W)) out_if ();

    conv_kernel_engine dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .s_in        (in_if),
        .m_out       (out_if),
        .i_coef_we   (coef_we),
        .i_coef_addr (coef_addr),
        .i_coef_data (coef_data),
        .i_shift     (shift),
        .i_commit    (commit),
        .o_sat       (o_sat),
        .i_sat_clr   (sat_clr)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: collects completed beats and checks hold-while-stalled.
    int   got_q[$];
    int   got_last_q[$];
    logic prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic prev_last;

    always @(negedge i_clk) begin
        if (i_reset_n && prev_stall) begin
            check("hold_valid", int'(out_if.valid), 1);
            check("hold_data", int'(out_if.data), int'(prev_data));
            check("hold_last", int'(out_if.last), int'(prev_last));
        end
        if (i_reset_n && out_if.valid && out_if.ready) begin
            got_q.push_back(int'(out_if.data));
            got_last_q.push_back(int'(out_if.last));
        end
        prev_stall = i_reset_n && out_if.valid && !out_if.ready;
        prev_data  = out_if.data;
        prev_last  = out_if.last;
    end

    function automatic logic [WIN_W-1:0] win_of(input logic [7:0] centre, input logic [7:0] other);
        logic [WIN_W-1:0] w;
        for (int k = 0; k < NTAPS; k++) w[8*k +: 8] = (k == 4) ? centre : other;
        return w;
    endfunction

    function automatic logic [KER_W-1:0] kern_of(input int centre, input int other);
        logic [KER_W-1:0] kp;
        for (int k = 0; k < NTAPS; k++) kp[8*k +: 8] = 8'((k == 4) ? centre : other);
        return kp;
    endfunction

    // Reference: weighted sum, rounded arithmetic shift, clamp to pixel range.
    task automatic model(input logic [WIN_W-1:0] win, input logic [KER_W-1:0] kern,
                         input int sh, output int y, output bit sat);
        int sum;
        sum = 0;
        for (int k = 0; k < NTAPS; k++) begin
            sum += int'(win[8*k +: 8]) * int'($signed(kern[8*k +: 8]));
        end
        y = (sh > 0) ? ((sum + (1 << (sh - 1))) >>> sh) : sum;
        sat = 1'b0;
        if (y < 0) begin
            y = 0;
            sat = 1'b1;
        end else if (y > 255) begin
            y = 255;
            sat = 1'b1;
        end
    endtask

    task automatic load_kernel(input logic [KER_W-1:0] kern, input int sh);
        for (int i = 0; i < NTAPS; i++) begin
            @(negedge i_clk);
            coef_we   = 1'b1;
            coef_addr = 4'(i);
            coef_data = kern[8*i +: 8];
        end
        @(negedge i_clk);
        coef_we = 1'b0;
        shift   = 4'(sh);
        commit  = 1'b1;
        @(negedge i_clk);
        commit  = 1'b0;
    endtask

    task automatic clear_sat();
        @(negedge i_clk);
        sat_clr = 1'b1;
        @(negedge i_clk);
        sat_clr = 1'b0;
    endtask

    // Sends one beat into an idle pipeline; lat = cycles after the accept
    // cycle until o_valid is seen (sampled 1 time unit after each edge).
    task automatic send_single(input logic [WIN_W-1:0] win, input logic last, output int lat);
        int n;
        @(negedge i_clk);
        in_if.valid = 1'b1;
        in_if.data  = win;
        in_if.last  = last;
        n = 0;
        while (!in_if.ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        @(posedge i_clk);
        #1;
        in_if.valid = 1'b0;
        lat = 1;
        while (!out_if.valid && lat < 20) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [WIN_W-1:0] win;
        logic [KER_W-1:0] kern;
        int               sh;
        int               exp_y;
        bit               exp_sat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat, y, w;
        bit s, any_sat;
        logic [KER_W-1:0] k_a, k_b, k_c, k_r;
        logic [WIN_W-1:0] cw[5];
        int sh_r, sent, cyc;
        bit fire;
        int exp_y_q[$];
        int exp_last_q[$];

        vecs[0] = '{win_of(8'h5A, 8'hFF), kern_of(1, 0),  0, 8'h5A, 1'b0};
        vecs[1] = '{win_of(8'hFF, 8'hFF), kern_of(1, 1),  3, 255,   1'b1};
        vecs[2] = '{win_of(8'h40, 8'h40), kern_of(8, -1), 0, 0,     1'b0};
        vecs[3] = '{win_of(8'h80, 8'h00), kern_of(8, -1), 0, 255,   1'b1};
        vecs[4] = '{win_of(8'h10, 8'h10), kern_of(1, 1),  3, 18,    1'b0};
        vecs[5] = '{win_of(8'h00, 8'h10), kern_of(8, -1), 0, 0,     1'b1};
        vecs[6] = '{win_of(8'h0A, 8'h00), kern_of(3, 0),  2, 8,     1'b0};
        vecs[7] = '{win_of(8'hFF, 8'h00), kern_of(1, 0),  0, 255,   1'b0};

        i_reset_n    = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.last   = 1'b0;
        out_if.ready = 1'b1;
        coef_we      = 1'b0;
        coef_addr    = '0;
        coef_data    = '0;
        shift        = '0;
        commit       = 1'b0;
        sat_clr      = 1'b0;

        #12;
        check("rst_o_valid", int'(out_if.valid), 0);
        check("rst_o_data", int'(out_if.data), 0);
        check("rst_o_last", int'(out_if.last), 0);
        check("rst_o_sat", int'(o_sat), 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;
        check("rst_o_ready", int'(in_if.ready), 1);

        // Reset-state bank must already be identity before any load.
        send_single(win_of(8'h5A, 8'hFF), 1'b1, lat);
        check("ident_lat", lat, 3);
        check("ident_data", int'(out_if.data), 8'h5A);
        check("ident_last", int'(out_if.last), 1);

        for (int i = 0; i < 8; i++) begin
            load_kernel(vecs[i].kern, vecs[i].sh);
            clear_sat();
            check("sat_cleared", int'(o_sat), 0);
            send_single(vecs[i].win, 1'(i % 2), lat);
            check("vec_lat", lat, 3);
            check("vec_data", int'(out_if.data), vecs[i].exp_y);
            check("vec_last", int'(out_if.last), i % 2);
            @(posedge i_clk);
            #1;
            check("vec_sat", int'(o_sat), int'(vecs[i].exp_sat));
        end

        // Clamp and clear in the same cycle: set wins.
        load_kernel(kern_of(8, -1), 0);
        clear_sat();
        @(negedge i_clk);
        sat_clr = 1'b1;
        send_single(win_of(8'h80, 8'h00), 1'b0, lat);
        check("setwins_sat", int'(o_sat), 1);
        @(negedge i_clk);
        sat_clr = 1'b0;
        @(negedge i_clk);
        check("setwins_hold", int'(o_sat), 1);

        // Commit coincident with the 3rd beat of a burst.
        k_a = kern_of(1, 0);
        k_b = kern_of(1, 1);
        k_c = k_b;
        k_c[7:0] = 8'd5;
        load_kernel(k_a, 0);
        for (int i = 0; i < NTAPS; i++) begin
            @(negedge i_clk);
            coef_we   = 1'b1;
            coef_addr = 4'(i);
            coef_data = k_b[8*i +: 8];
        end
        @(negedge i_clk);
        coef_we = 1'b0;
        shift   = 4'd2;
        for (int i = 0; i < 5; i++) cw[i] = WIN_W'({$urandom(), $urandom(), $urandom()});
        @(posedge i_clk);
        got_q.delete();
        got_last_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            in_if.valid = 1'b1;
            in_if.data  = cw[i];
            in_if.last  = 1'(i % 2);
            commit      = (i == 2);
            coef_we     = (i == 2) || (i == 3);
            coef_addr   = (i == 2) ? 4'd0 : 4'd9;
            coef_data   = (i == 2) ? 8'd5 : 8'h7F;
        end
        @(negedge i_clk);
        in_if.valid = 1'b0;
        commit      = 1'b0;
        coef_we     = 1'b0;
        w = 0;
        while (got_q.size() < 4 && w < 40) begin
            @(posedge i_clk);
            w++;
        end
        check("commit_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) begin
                if (i < 3) model(cw[i], k_a, 0, y, s);
                else       model(cw[i], k_b, 2, y, s);
                check("commit_data", got_q[i], y);
                check("commit_last", got_last_q[i], i % 2);
            end
        end
        @(negedge i_clk);
        commit = 1'b1;
        @(negedge i_clk);
        commit = 1'b0;
        send_single(cw[4], 1'b0, lat);
        model(cw[4], k_c, 2, y, s);
        check("commit2_lat", lat, 3);
        check("commit2_data", int'(out_if.data), y);

        // Randomized stream with random backpressure against the model.
        for (int i = 0; i < NTAPS; i++) k_r[8*i +: 8] = 8'(int'($urandom_range(0, 6)) - 3);
        sh_r = int'($urandom_range(0, 4));
        load_kernel(k_r, sh_r);
        clear_sat();
        any_sat = 1'b0;
        @(posedge i_clk);
        got_q.delete();
        got_last_q.delete();
        sent = 0;
        cyc  = 0;
        while (got_q.size() < NSTREAM && cyc < 3000) begin
            @(negedge i_clk);
            cyc++;
            fire = in_if.valid && in_if.ready;
            if (fire) begin
                model(in_if.data, k_r, sh_r, y, s);
                exp_y_q.push_back(y);
                exp_last_q.push_back(int'(in_if.last));
                any_sat |= s;
                sent++;
            end
            @(posedge i_clk);
            #1;
            if (fire) in_if.valid = 1'b0;
            if (!in_if.valid && sent < NSTREAM && $urandom_range(0, 3) != 0) begin
                in_if.valid = 1'b1;
                in_if.data  = WIN_W'({$urandom(), $urandom(), $urandom()});
                in_if.last  = 1'($urandom_range(0, 1));
            end
            out_if.ready = 1'($urandom_range(0, 1));
        end
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        repeat (10) @(posedge i_clk);
        check("stream_count", got_q.size(), NSTREAM);
        check("stream_sent", exp_y_q.size(), NSTREAM);
        for (int i = 0; i < NSTREAM; i++) begin
            if (i < got_q.size() && i < exp_y_q.size()) begin
                check("stream_data", got_q[i], exp_y_q[i]);
                check("stream_last", got_last_q[i], exp_last_q[i]);
            end
        end
        check("stream_sat", int'(o_sat), int'(any_sat));

        // Reset with a full, stalled pipeline and sticky saturation set.
        load_kernel(kern_of(8, -1), 0);
        out_if.ready = 1'b0;
        @(negedge i_clk);
        in_if.valid = 1'b1;
        in_if.data  = win_of(8'h80, 8'h00);
        in_if.last  = 1'b0;
        repeat (6) @(negedge i_clk);
        check("full_o_ready", int'(in_if.ready), 0);
        check("full_o_valid", int'(out_if.valid), 1);
        check("full_o_sat", int'(o_sat), 1);
        @(posedge i_clk);
        #2;
        i_reset_n   = 1'b0;
        in_if.valid = 1'b0;
        #1;
        check("midrst_o_valid", int'(out_if.valid), 0);
        check("midrst_o_sat", int'(o_sat), 0);
        check("midrst_o_data", int'(out_if.data), 0);
        check("midrst_o_ready", int'(in_if.ready), 1);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset_n    = 1'b1;
        out_if.ready = 1'b1;
        send_single(win_of(8'h33, 8'hFF), 1'b1, lat);
        check("postrst_lat", lat, 3);
        check("postrst_data", int'(out_if.data), 8'h33);
        check("postrst_last", int'(out_if.last), 1);

        repeat (3) @(posedge i_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
